irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Shares the single CPU interrupt line (irq_pin) among the on-board peripherals
//  (ADC, keypad debouncer, RPM counter, spare) on the 8-bit CPU bus.
//  - Latches rising edges from each source into a pending register.
//  - Applies a mask and picks the highest-priority source (lowest index).
//  - Drives irq_pin and holds it until the CPU acknowledges.
//  - Forces a deassert gap so the CPU's edge-sensitive input always sees a fresh edge.
//  - Occupies one csN window of the top-level peripheral decode.
// PARAMETERS
//  N_SRC        4   number of interrupt sources, 1..8
//  HOLDOFF_CYC  8   clk cycles irq_pin stays inactive after an ack, >=1
//  HW           4   width of the holdoff counter, must hold HOLDOFF_CYC
// PORTS
//  clk      in   1      system clock, all state on posedge
//  reset    in   1      asynchronous, active-high; clears all state
//  irq_src  in   N_SRC  source requests, clk-synchronous; rising edge = event
//  cs       in   1      peripheral select, active-high (csN bit)
//  addr     in   11     register address; only addr[1:0] decoded, upper bits alias
//  wrBus    in   8      write data, valid when we=1
//  we       in   1      one-cycle write strobe; ignored unless cs=1
//  rdBus    out  8      read data, combinational from addr; 0 when cs=0
//  irq_pin  out  1      interrupt to CPU, polarity set by CTRL.POL
// BEHAVIOUR
//  Registers (unused bits read 0, writes to them ignored):
//   0 PEND   R/W1C  bit i set on a rising edge of irq_src[i]; write 1 clears
//   1 MASK   RW     bit i=1 enables source i; reset 0
//   2 ACTIVE RO     {valid,4'b0,id[2:0]}; valid=1 in ASSERT only
//   3 CTRL   RW     bit0 EN (global enable), bit1 POL (1 = irq_pin active-low); reset 0
//  Reset values: PEND=0, MASK=0, CTRL=0, state IDLE, irq_pin=0.
//   Asserting reset mid-operation aborts at once; no pending event survives.
//  Edge detect: src_q <= irq_src (resets to 0); edge = irq_src & ~src_q.
//   PEND[i] sets on the cycle after the edge.
//   Same-cycle edge and W1C on the same bit: the set wins and PEND stays 1.
//  req = PEND & MASK[N_SRC-1:0]; sel = lowest set index of req.
//  State machine (irq_act is 1 only in ASSERT):
//   IDLE    EN & |req -> latch id=sel, go ASSERT; irq_act rises on the next posedge.
//   ASSERT  id is frozen, even if a higher-priority source arrives.
//           Exits to HOLDOFF when any of:
//           - W1C clears PEND[id] (the ack)
//           - MASK[id] is written 0
//           - EN is written 0
//   HOLDOFF counter loads HOLDOFF_CYC-1 and counts down; at 0 go IDLE.
//  Re-arbitration happens in IDLE only, so a still-pending source re-raises
//   irq_pin HOLDOFF_CYC+1 cycles after the ack.
//  irq_pin = irq_act ^ CTRL.POL. Registered, so no glitches except the
//   immediate flip when POL is written.
//  Reads have no side effects. Writing PEND with a bit that is already 0 does nothing.
//  Source indices >= N_SRC read 0 in PEND/MASK and never request.
// TESTING
//  1. Reset; MASK=0x01, CTRL=0x01; pulse irq_src[0] for 1 cycle
//     -> PEND=0x01, irq_pin=1 two cycles after the edge, ACTIVE=0x80.
//  2. From test 1, write PEND=0x01
//     -> irq_pin=0 next cycle; stays 0 for 8 cycles; PEND=0x00; ACTIVE=0x00.
//  3. MASK=0x0F, EN=1; edges on src[2] and src[1] in the same cycle
//     -> ACTIVE=0x81. Ack bit1 -> after 8 holdoff cycles ACTIVE=0x82,
//     irq_pin=1 again.
//  4. Edge on src[3] in the same cycle as a W1C of PEND=0x08
//     -> PEND[3] remains 1.
//  5. CTRL=0x03, no requests -> irq_pin=1 (idle, active-low).
//     Pulse src[0] with MASK=0x01 -> irq_pin=0.
//     Write MASK=0 -> irq_pin=1 next cycle; PEND[0] still 1.
//  6. Assert reset during ASSERT
//     -> asynchronously irq_pin=0, PEND=MASK=CTRL=0;
//     after release no interrupt occurs without a new edge.

Source files
------------

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches source edges into PEND, masks them, picks the lowest
// index, and drives a single CPU interrupt line with a post-ack deassert gap.
module irq_arbiter #(
    parameter int N_SRC       = 4,
    parameter int HOLDOFF_CYC = 8,
    parameter int HW          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             cs,
    input  logic [10:0]      addr,
    input  logic [7:0]       wrBus,
    input  logic             we,
    output logic [7:0]       rdBus,
    output logic             irq_pin
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    logic [N_SRC-1:0] src_q_r;
    logic [N_SRC-1:0] pend_r;
    logic [N_SRC-1:0] mask_r;
    logic [1:0]       ctrl_r;
    state_t           state_r;
    logic             irq_act_r;
    logic [2:0]       id_r;
    logic [HW-1:0]    cnt_r;

    logic [N_SRC-1:0] edge_s;
    logic [N_SRC-1:0] req_s;
    logic [N_SRC-1:0] clr_s;
    logic [7:0]       pend_pad_s;
    logic [7:0]       mask_pad_s;
    logic [7:0]       req_pad_s;
    logic [2:0]       sel_s;
    logic             wr_s;
    logic             wr_pend_s;
    logic             wr_mask_s;
    logic             wr_ctrl_s;
    logic             drop_s;
    logic             unused_s;

    // Lowest set bit wins, so scan downward and let the last hit stand.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign unused_s  = ^{addr[10:2], wrBus};
    assign edge_s    = irq_src & ~src_q_r;
    assign req_s     = pend_r & mask_r;
    assign wr_s      = cs & we;
    assign wr_pend_s = wr_s & (addr[1:0] == 2'd0);
    assign wr_mask_s = wr_s & (addr[1:0] == 2'd1);
    assign wr_ctrl_s = wr_s & (addr[1:0] == 2'd3);
    assign sel_s     = lowest_idx(req_pad_s);
    assign irq_pin   = irq_act_r ^ ctrl_r[1];

    // Zero-extend per-source vectors to the bus width and build the W1C mask.
    always_comb begin
        pend_pad_s = 8'd0;
        mask_pad_s = 8'd0;
        req_pad_s  = 8'd0;
        pend_pad_s[N_SRC-1:0] = pend_r;
        mask_pad_s[N_SRC-1:0] = mask_r;
        req_pad_s[N_SRC-1:0]  = req_s;
        if (wr_pend_s) begin
            clr_s = wrBus[N_SRC-1:0];
        end else begin
            clr_s = {N_SRC{1'b0}};
        end
    end

    // Any of ack, mask-off or global disable of the frozen source ends ASSERT.
    always_comb begin
        drop_s = (wr_pend_s & wrBus[id_r])
               | (wr_mask_s & ~wrBus[id_r])
               | (wr_ctrl_s & ~wrBus[0]);
    end

    // Register file and edge capture; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q_r <= {N_SRC{1'b0}};
            pend_r  <= {N_SRC{1'b0}};
            mask_r  <= {N_SRC{1'b0}};
            ctrl_r  <= 2'b00;
        end else begin
            src_q_r <= irq_src;
            pend_r  <= (pend_r & ~clr_s) | edge_s;
            if (wr_mask_s) begin
                mask_r <= wrBus[N_SRC-1:0];
            end
            if (wr_ctrl_s) begin
                ctrl_r <= wrBus[1:0];
            end
        end
    end

    // Arbitration FSM; id only changes in IDLE so a late higher-priority source waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            irq_act_r <= 1'b0;
            id_r      <= 3'd0;
            cnt_r     <= {HW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ctrl_r[0] && (|req_s)) begin
                        state_r   <= ST_ASSERT;
                        id_r      <= sel_s;
                        irq_act_r <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (drop_s) begin
                        state_r   <= ST_HOLDOFF;
                        irq_act_r <= 1'b0;
                        cnt_r     <= HW'(HOLDOFF_CYC - 1);
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_r == {HW{1'b0}}) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - {{(HW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    irq_act_r <= 1'b0;
                end
            endcase
        end
    end

    // Side-effect-free read mux; ACTIVE shows the id only while asserted.
    always_comb begin
        rdBus = 8'd0;
        if (cs) begin
            case (addr[1:0])
                2'd0:    rdBus = pend_pad_s;
                2'd1:    rdBus = mask_pad_s;
                2'd2:    rdBus = {irq_act_r, 4'b0000, (irq_act_r ? id_r : 3'd0)};
                2'd3:    rdBus = {6'd0, ctrl_r};
                default: rdBus = 8'd0;
            endcase
        end else begin
            rdBus = 8'd0;
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: a cycle-vector table for the basic flow and
// hand-written sequences for holdoff timing, polarity and asynchronous reset.
module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_src;
    logic        cs;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wrBus;
    logic [7:0]  rdBus;
    logic        irq_pin;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  src;
        logic        cs;
        logic        we;
        logic [10:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[7];

    irq_arbiter #(.N_SRC(4), .HOLDOFF_CYC(8), .HW(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .cs      (cs),
        .addr    (addr),
        .wrBus   (wrBus),
        .we      (we),
        .rdBus   (rdBus),
        .irq_pin (irq_pin)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
    task automatic step(input logic [3:0] s, input logic c, input logic w,
                        input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        irq_src = s;
        cs      = c;
        we      = w;
        addr    = a;
        wrBus   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{4'h0, 1'b1, 1'b1, 11'h001, 8'h01, 8'h01, 1'b0};
        vecs[1] = '{4'h0, 1'b1, 1'b1, 11'h003, 8'h01, 8'h01, 1'b0};
        vecs[2] = '{4'h1, 1'b1, 1'b0, 11'h000, 8'h00, 8'h01, 1'b0};
        vecs[3] = '{4'h0, 1'b1, 1'b0, 11'h000, 8'h00, 8'h01, 1'b1};
        vecs[4] = '{4'h0, 1'b1, 1'b0, 11'h402, 8'h00, 8'h80, 1'b1};
        vecs[5] = '{4'h0, 1'b1, 1'b1, 11'h7FC, 8'h01, 8'h00, 1'b0};
        vecs[6] = '{4'h0, 1'b1, 1'b0, 11'h002, 8'h00, 8'h00, 1'b0};

        reset   = 1'b1;
        irq_src = 4'h0;
        cs      = 1'b0;
        we      = 1'b0;
        addr    = 11'h000;
        wrBus   = 8'h00;
        repeat (2) @(negedge clk);
        chk1("reset_irq", irq_pin, 1'b0);
        cs = 1'b1;
        for (int a = 0; a < 4; a++) begin
            addr = 11'(a);
            #1;
            chk8($sformatf("reset_reg%0d", a), rdBus, 8'h00);
        end
        cs = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Mask/enable, single edge on src0, then ack
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].src, vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].wd);
            chk8($sformatf("vec%0d_rd", i), rdBus, vecs[i].exp_rd);
            chk1($sformatf("vec%0d_irq", i), irq_pin, vecs[i].exp_irq);
        end
        for (int k = 2; k <= 8; k++) begin
            step(4'h0, 1'b1, 1'b0, 11'h002, 8'h00);
            chk1($sformatf("holdoff1_irq_%0d", k), irq_pin, 1'b0);
        end

        // Simultaneous edges on src1/src2; ack src1, src2 follows after holdoff
        step(4'h0, 1'b1, 1'b1, 11'h001, 8'h0F);
        step(4'h6, 1'b1, 1'b0, 11'h000, 8'h00);
        chk8("t3_pend", rdBus, 8'h06);
        step(4'h0, 1'b1, 1'b0, 11'h002, 8'h00);
        chk8("t3_active1", rdBus, 8'h81);
        chk1("t3_irq1", irq_pin, 1'b1);
        step(4'h0, 1'b1, 1'b1, 11'h000, 8'h02);
        chk8("t3_pend_after_ack", rdBus, 8'h04);
        chk1("t3_irq_ack", irq_pin, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(4'h0, 1'b1, 1'b0, 11'h002, 8'h00);
            chk8($sformatf("t3_gap_active_%0d", k), rdBus, 8'h00);
            chk1($sformatf("t3_gap_irq_%0d", k), irq_pin, 1'b0);
        end
        step(4'h0, 1'b1, 1'b0, 11'h002, 8'h00);
        chk8("t3_active2", rdBus, 8'h82);
        chk1("t3_irq2", irq_pin, 1'b1);
        step(4'h0, 1'b1, 1'b1, 11'h000, 8'h04);
        chk8("t3_pend_clear", rdBus, 8'h00);

        // Edge on src3 in the same cycle as its W1C: the set wins
        step(4'h8, 1'b1, 1'b1, 11'h000, 8'h08);
        chk8("t4_set_wins", rdBus, 8'h08);
        step(4'h0, 1'b1, 1'b1, 11'h000, 8'h08);
        chk8("t4_clear", rdBus, 8'h00);
        for (int k = 0; k < 8; k++) begin
            step(4'h0, 1'b0, 1'b0, 11'h000, 8'h00);
        end
        chk8("deselect_reads_zero", rdBus, 8'h00);
        chk1("t4_idle_irq", irq_pin, 1'b0);

        // Active-low polarity and mask-off as an exit from ASSERT
        step(4'h0, 1'b1, 1'b1, 11'h003, 8'h03);
        chk1("t5_idle_low_pol", irq_pin, 1'b1);
        step(4'h0, 1'b1, 1'b1, 11'h001, 8'h01);
        step(4'h1, 1'b1, 1'b0, 11'h000, 8'h00);
        chk8("t5_pend", rdBus, 8'h01);
        chk1("t5_pre_assert", irq_pin, 1'b1);
        step(4'h0, 1'b1, 1'b0, 11'h002, 8'h00);
        chk8("t5_active", rdBus, 8'h80);
        chk1("t5_asserted", irq_pin, 1'b0);
        step(4'h0, 1'b1, 1'b1, 11'h001, 8'h00);
        chk1("t5_mask_off", irq_pin, 1'b1);
        step(4'h0, 1'b1, 1'b0, 11'h000, 8'h00);
        chk8("t5_pend_kept", rdBus, 8'h01);

        // Re-enable the mask; the still-pending source re-raises after holdoff
        step(4'h0, 1'b1, 1'b1, 11'h001, 8'h01);
        for (int k = 3; k <= 8; k++) begin
            step(4'h0, 1'b1, 1'b0, 11'h002, 8'h00);
            chk1($sformatf("t6_gap_irq_%0d", k), irq_pin, 1'b1);
        end
        step(4'h0, 1'b1, 1'b0, 11'h002, 8'h00);
        chk8("t6_active", rdBus, 8'h80);
        chk1("t6_reasserted", irq_pin, 1'b0);

        // Asynchronous reset in the middle of ASSERT
        #2;
        reset = 1'b1;
        #1;
        chk1("t6_async_irq", irq_pin, 1'b0);
        cs = 1'b1;
        we = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr = 11'(a);
            #1;
            chk8($sformatf("t6_async_reg%0d", a), rdBus, 8'h00);
        end
        @(negedge clk);
        reset = 1'b0;
        step(4'h0, 1'b1, 1'b1, 11'h001, 8'h01);
        step(4'h0, 1'b1, 1'b1, 11'h003, 8'h01);
        for (int k = 0; k < 4; k++) begin
            step(4'h0, 1'b1, 1'b0, 11'h000, 8'h00);
            chk8($sformatf("t6_no_pend_%0d", k), rdBus, 8'h00);
            chk1($sformatf("t6_no_irq_%0d", k), irq_pin, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
